// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM move sequencer and its command FIFO.
package pwm_seq_pkg;

    localparam int NUM_CH      = 8;
    localparam int CH_W        = $clog2(NUM_CH);
    localparam int CH_STRIDE   = 4;
    // Widest duty/dwell a command can carry; narrower builds zero-extend into it.
    localparam int CMD_FIELD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        DWELL,
        VERIFY
    } seq_state_e;

    typedef struct packed {
        logic [CH_W-1:0]        ch;
        logic [CMD_FIELD_W-1:0] duty;
        logic [CMD_FIELD_W-1:0] dwell;
    } pwm_cmd_t;

endpackage

// File: rtl/pwm_move_sequencer_fifo.sv
// Synchronous command FIFO with flush, occupancy count and async active-high reset.
module pwm_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == LW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // Pointers are AW bits wide, so DEPTH being a power of 2 gives the wrap for free.
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/pwm_move_sequencer.sv
// Sequences queued servo moves onto the PWM core register port: write duty, then dwell.
// Define PWM_SEQ_READBACK_EN to add a read-back VERIFY step and the sticky err output.
module pwm_move_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter int         DUTY_W    = 16,
    parameter int         DWELL_W   = 24,
    parameter logic [7:0] ADDR_BASE = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [CH_W-1:0]          cmd_ch,
    input  logic [DUTY_W-1:0]        cmd_duty,
    input  logic [DWELL_W-1:0]       cmd_dwell,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               pwm_addr,
    output logic [31:0]              pwm_data,
    output logic                     pwm_wr,
    output logic                     pwm_rd,
    input  logic [31:0]              pwm_q
`ifdef PWM_SEQ_READBACK_EN
    ,
    output logic                     err
`endif
);

    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int FIFO_W = CH_W + DUTY_W + DWELL_W;

    seq_state_e         state_q, state_d;
    logic [7:0]         addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               wr_c, done_c;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [LVL_W-1:0]   fifo_level, lvl_nxt;
    logic [FIFO_W-1:0]  fifo_wdata, fifo_rdata;
    pwm_cmd_t           head;
    logic               unused_sink;

`ifdef PWM_SEQ_READBACK_EN
    logic               vphase_q, vphase_d;
    logic               err_q, err_d;
    logic               rd_c;
`endif

    assign fifo_wdata = {cmd_ch, cmd_duty, cmd_dwell};
    assign fifo_push  = cmd_valid && !fifo_full && !abort;
    assign fifo_pop   = (state_q == LOAD) && !abort;

    pwm_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        head       = '0;
        head.ch    = fifo_rdata[FIFO_W-1 -: CH_W];
        head.duty  = CMD_FIELD_W'(fifo_rdata[DWELL_W +: DUTY_W]);
        head.dwell = CMD_FIELD_W'(fifo_rdata[0 +: DWELL_W]);
    end

    // Occupancy after this edge, so the registered busy lines up with state and level.
    always_comb begin
        lvl_nxt = fifo_level;
        if (abort)                        lvl_nxt = '0;
        else if (fifo_push && !fifo_pop)  lvl_nxt = fifo_level + LVL_W'(1);
        else if (!fifo_push && fifo_pop)  lvl_nxt = fifo_level - LVL_W'(1);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        wr_c    = 1'b0;
        done_c  = 1'b0;
`ifdef PWM_SEQ_READBACK_EN
        vphase_d = vphase_q;
        err_d    = err_q;
        rd_c     = 1'b0;
`endif
        case (state_q)
            IDLE: if (!fifo_empty) state_d = LOAD;
            LOAD: begin
                addr_d  = ADDR_BASE + 8'(head.ch) * 8'(CH_STRIDE);
                data_d  = head.duty;
                dwell_d = head.dwell[DWELL_W-1:0];
                state_d = WRITE;
            end
            WRITE: begin
                wr_c  = 1'b1;
                cnt_d = dwell_q;
`ifdef PWM_SEQ_READBACK_EN
                state_d = VERIFY;
`else
                state_d = DWELL;
`endif
            end
            VERIFY: begin
`ifdef PWM_SEQ_READBACK_EN
                // First cycle issues the read, second cycle sees the core's data_out.
                if (!vphase_q) begin
                    rd_c     = 1'b1;
                    vphase_d = 1'b1;
                end else begin
                    vphase_d = 1'b0;
                    if (pwm_q[DUTY_W-1:0] != data_q[DUTY_W-1:0]) err_d = 1'b1;
                    state_d = DWELL;
                end
`else
                state_d = IDLE;
`endif
            end
            DWELL: begin
                if (cnt_q == '0) begin
                    done_c  = 1'b1;
                    state_d = fifo_empty ? IDLE : LOAD;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // An in-flight pwm_wr still completes; everything else is cancelled.
        if (abort) begin
            state_d = IDLE;
            done_c  = 1'b0;
            addr_d  = addr_q;
            data_d  = data_q;
`ifdef PWM_SEQ_READBACK_EN
            vphase_d = 1'b0;
            err_d    = 1'b0;
`endif
        end
        busy_d = (state_d != IDLE) || (lvl_nxt != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

`ifdef PWM_SEQ_READBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vphase_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            vphase_q <= vphase_d;
            err_q    <= err_d;
        end
    end
    assign pwm_rd = rd_c;
    assign err    = err_q;
`else
    assign pwm_rd = 1'b0;
`endif

    assign unused_sink = ^{head.dwell, pwm_q};

    assign cmd_ready = !fifo_full;
    assign busy      = busy_q;
    assign done      = done_c;
    assign level     = fifo_level;
    assign pwm_addr  = addr_q;
    assign pwm_data  = data_q;
    assign pwm_wr    = wr_c;

endmodule

// File: tb/tb_pwm_move_sequencer.sv
// Self-checking bench: timeline model of queued moves plus directed scenario checks.
module tb_pwm_move_sequencer;

    localparam int DEPTH   = 8;
    localparam int DUTY_W  = 16;
    localparam int DWELL_W = 24;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              abort = 1'b0;
    logic [2:0]        cmd_ch = '0;
    logic [DUTY_W-1:0] cmd_duty = '0;
    logic [DWELL_W-1:0] cmd_dwell = '0;
    logic [31:0]       pwm_q = '0;
    logic              cmd_ready, busy, done, pwm_wr, pwm_rd;
    logic [3:0]        level;
    logic [7:0]        pwm_addr;
    logic [31:0]       pwm_data;
`ifdef PWM_SEQ_READBACK_EN
    logic              err;
`endif

    pwm_move_sequencer #(.DEPTH(DEPTH), .DUTY_W(DUTY_W), .DWELL_W(DWELL_W), .ADDR_BASE(8'h00)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
        .cmd_duty(cmd_duty), .cmd_dwell(cmd_dwell), .abort(abort), .busy(busy), .done(done),
        .level(level), .pwm_addr(pwm_addr), .pwm_data(pwm_data), .pwm_wr(pwm_wr),
        .pwm_rd(pwm_rd), .pwm_q(pwm_q)
`ifdef PWM_SEQ_READBACK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Model: a move popped at edge W writes in cycle W and is done in cycle W+dwell+1.
    // The next write comes two cycles after the first cycle (>= last done) with a non-empty queue.
    typedef struct { logic [2:0] ch; logic [15:0] duty; int dwell; } mv_t;
    mv_t         mq[$];
    mv_t         m;
    bit          sched = 0;
    int          sched_w = 0;
    int          cur_w = -100, cur_d = -100, free_d = 0;
    logic [7:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst || abort) begin
            mq.delete();
            sched  = 0;
            cur_w  = -100;
            cur_d  = -100;
            free_d = cyc;
            if (rst) begin
                m_addr = '0;
                m_data = '0;
            end
        end else begin
            if (cmd_valid && mq.size() < DEPTH) mq.push_back('{cmd_ch, cmd_duty, int'(cmd_dwell)});
            if (sched && cyc == sched_w) begin
                m = mq.pop_front();
                sched  = 0;
                cur_w  = cyc;
                cur_d  = cyc + m.dwell + 1;
                free_d = cur_d;
                m_addr = 8'(int'(m.ch) * 4);
                m_data = {16'h0, m.duty};
            end
            if (!sched && mq.size() > 0 && cyc >= free_d) begin
                sched   = 1;
                sched_w = cyc + 2;
            end
        end
    end

    typedef struct { int c; logic [7:0] a; logic [31:0] d; } wr_t;
    wr_t wr_log[$];
    int  done_log[$];
    int  busy_fall = -1;
    bit  prev_busy = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", cmd_ready, 1);
            chk("rst_level", level, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_wr", pwm_wr, 0);
            chk("rst_addr", pwm_addr, 0);
            chk("rst_data", pwm_data, 0);
        end else begin
            chk("wr", pwm_wr, (cyc == cur_w) ? 1 : 0);
            chk("done", done, (cyc == cur_d && !abort) ? 1 : 0);
            chk("busy", busy, (mq.size() != 0 || (cyc >= cur_w && cyc <= cur_d)) ? 1 : 0);
            chk("level", level, mq.size());
            chk("cmd_ready", cmd_ready, (mq.size() < DEPTH) ? 1 : 0);
            chk("addr", pwm_addr, m_addr);
            chk("data", pwm_data, m_data);
        end
        chk("rd", pwm_rd, 0);
        if (pwm_wr) wr_log.push_back('{cyc, pwm_addr, pwm_data});
        if (done) done_log.push_back(cyc);
        if (prev_busy && !busy) busy_fall = cyc;
        prev_busy = busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] ch, input logic [15:0] duty, input int dwell);
        cmd_valid = 1; cmd_ch = ch; cmd_duty = duty; cmd_dwell = DWELL_W'(dwell);
        tick();
        cmd_valid = 0;
    endtask

    task automatic push_hs(input logic [2:0] ch, input logic [15:0] duty, input int dwell, output bit ok);
        int n = 0;
        ok = 0;
        cmd_valid = 1; cmd_ch = ch; cmd_duty = duty; cmd_dwell = DWELL_W'(dwell);
        while (!cmd_ready && n < 2000) begin tick(); n++; end
        if (cmd_ready) begin tick(); ok = 1; end
        cmd_valid = 0;
    endtask

    task automatic clr_logs();
        wr_log.delete();
        done_log.delete();
        busy_fall = -1;
    endtask

    initial begin
        int e, w;
        bit ok;
        repeat (3) tick();
        chk("init_ready", cmd_ready, 1);
        chk("init_level", level, 0);
        chk("init_busy", busy, 0);
        rst = 0;
        tick();

        // Single move: write lands on the 3rd edge counting the push edge.
        clr_logs();
        push(3'd2, 16'h1234, 5);
        e = cyc;
        repeat (12) tick();
        chk("t1_nwr", wr_log.size(), 1);
        chk("t1_ndone", done_log.size(), 1);
        if (wr_log.size() == 1 && done_log.size() == 1) begin
            chk("t1_lat", wr_log[0].c - e, 2);
            chk("t1_addr", wr_log[0].a, 8'h08);
            chk("t1_data", wr_log[0].d, 32'h00001234);
            chk("t1_wr2done", done_log[0] - wr_log[0].c, 6);
            chk("t1_busyfall", busy_fall - done_log[0], 1);
        end

        // Back-to-back moves.
        clr_logs();
        push(3'd0, 16'h00A0, 0);
        push(3'd1, 16'h00A1, 2);
        push(3'd7, 16'h00A7, 1);
        repeat (20) tick();
        chk("t2_nwr", wr_log.size(), 3);
        chk("t2_ndone", done_log.size(), 3);
        if (wr_log.size() == 3 && done_log.size() == 3) begin
            chk("t2_a0", wr_log[0].a, 8'h00);
            chk("t2_a1", wr_log[1].a, 8'h04);
            chk("t2_a2", wr_log[2].a, 8'h1C);
            chk("t2_sp0", done_log[0] - wr_log[0].c, 1);
            chk("t2_sp1", done_log[1] - wr_log[1].c, 3);
            chk("t2_sp2", done_log[2] - wr_log[2].c, 2);
            chk("t2_gap0", wr_log[1].c - done_log[0], 2);
            chk("t2_gap1", wr_log[2].c - done_log[1], 2);
        end

        // Fill while stalled on a long dwell; two excess pushes are dropped.
        clr_logs();
        push(3'd3, 16'h5000, 1000);
        repeat (4) tick();
        for (int i = 0; i < 10; i++) push(3'(i % 8), 16'h5100 + 16'(i), 2);
        chk("t3_full_level", level, 8);
        chk("t3_full_ready", cmd_ready, 0);
        repeat (1100) tick();
        chk("t3_nwr", wr_log.size(), 9);
        for (int i = 0; i < 8; i++)
            if (i + 1 < wr_log.size()) chk("t3_order", wr_log[i + 1].d, 32'h5100 + i);
        chk("t3_drained", level, 0);

        clr_logs();
        for (int i = 0; i < 20; i++) begin
            push_hs(3'(i % 8), 16'h6000 + 16'(i), 0, ok);
            chk("t3_push_ok", ok, 1);
        end
        repeat (120) tick();
        chk("t3_wrap_nwr", wr_log.size(), 20);
        for (int i = 0; i < 20; i++)
            if (i < wr_log.size()) begin
                chk("t3_wrap_data", wr_log[i].d, 32'h6000 + i);
                chk("t3_wrap_addr", wr_log[i].a, 8'((i % 8) * 4));
            end

        // Abort ten cycles into the first dwell.
        clr_logs();
        for (int i = 0; i < 4; i++) push(3'(4 + i), 16'h0AB0 + 16'(i), 50);
        for (int n = 0; n < 20 && wr_log.size() == 0; n++) tick();
        chk("t4_first_wr", wr_log.size(), 1);
        w = (wr_log.size() > 0) ? wr_log[0].c : cyc;
        for (int n = 0; n < 40 && cyc < w + 10; n++) tick();
        abort = 1;
        tick();
        abort = 0;
        chk("t4_level", level, 0);
        chk("t4_busy", busy, 0);
        repeat (80) tick();
        chk("t4_nwr", wr_log.size(), 1);
        chk("t4_ndone", done_log.size(), 0);

        // Asynchronous reset mid-dwell: outputs clear before any clock edge.
        clr_logs();
        push(3'd5, 16'h7777, 100);
        repeat (10) tick();
        chk("t5_busy_pre", busy, 1);
        @(posedge clk);
        #3 rst = 1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_level", level, 0);
        chk("t5_ready", cmd_ready, 1);
        chk("t5_addr", pwm_addr, 0);
        chk("t5_data", pwm_data, 0);
        tick();
        tick();
        rst = 0;
        tick();
        push(3'd6, 16'h0BEE, 0);
        repeat (6) tick();
        chk("t5_nwr", wr_log.size(), 2);
        chk("t5_ndone", done_log.size(), 1);
        if (wr_log.size() == 2) begin
            chk("t5_addr2", wr_log[1].a, 8'h18);
            chk("t5_data2", wr_log[1].d, 32'h00000BEE);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pwm_move_sequencer.md
Name: pwm_move_sequencer

Overview:
- Sequences servo moves onto the 8-channel PWM core's register port (addr/data_in/wr/rd).
- Software or the cube-solver FSM pushes move commands into an internal FIFO: channel, duty word and dwell time.
- The block writes each duty to the PWM core, then holds for the dwell time so the servo can settle before the next move issues.
- Sits between the Wishbone motor peripheral and the PWM core; it is the single owner of the PWM register port.

Parameters:
- DEPTH, 8, command FIFO entries (power of 2, ≥2).
- DUTY_W, 16, duty field width; zero-extended to 32 bits on pwm_data.
- DWELL_W, 24, dwell counter width, in clk cycles.
- ADDR_BASE, 8'h00, PWM core address of channel 0; channel n is at ADDR_BASE + 4*n.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command push request
- cmd_ready  out  1  FIFO not full
- cmd_ch  in  3  target PWM channel 0..7
- cmd_duty  in  DUTY_W  duty value
- cmd_dwell  in  DWELL_W  hold cycles after the write; 0 is legal
- abort  in  1  flush FIFO and stop the current dwell
- busy  out  1  FSM not IDLE or FIFO not empty
- done  out  1  one-cycle pulse when a move's dwell completes
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- pwm_addr  out  8  to PWM core addr
- pwm_data  out  32  to PWM core data_in
- pwm_wr  out  1  to PWM core wr; one-cycle pulse
- pwm_rd  out  1  to PWM core rd; held 0 unless the optional feature is enabled
- pwm_q  in  32  from PWM core data_out; used only by the optional feature

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO empty; FSM in IDLE.
  - All outputs 0, except cmd_ready = 1.
- FIFO:
  - Push when cmd_valid & cmd_ready; a push while full is ignored.
  - Pop happens in the LOAD state.
  - Simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo DEPTH.
  - A push to an empty FIFO is visible to the FSM the next cycle.
- FSM states:
  - IDLE: if the FIFO is non-empty, go to LOAD.
  - LOAD: pop the head entry into working registers (ch, duty, dwell); drive pwm_addr = ADDR_BASE + {ch,2'b00} and pwm_data = zero-extended duty; go to WRITE.
  - WRITE: pwm_wr = 1 for exactly this cycle; addr and data are stable from LOAD through WRITE. Load the counter with dwell; go to DWELL.
  - DWELL:
    - If the counter is 0, pulse done and go to LOAD when the FIFO is non-empty, else to IDLE.
    - Otherwise decrement the counter.
- Timing:
  - Latency from push into an idle, empty FIFO to pwm_wr is 3 cycles: the push edge, then IDLE→LOAD, then LOAD→WRITE.
  - Write-to-done spacing is dwell+1 cycles.
  - A dwell of 0 gives done on the cycle after WRITE.
- Between moves: pwm_addr and pwm_data keep their last values; pwm_wr is 0 outside WRITE.
- abort (synchronous, highest priority):
  - Empties the FIFO and forces IDLE on the next edge; no done pulse.
  - Abort during WRITE still lets the single pwm_wr pulse complete, since it is already asserted this cycle.
  - A push in the same cycle as abort is dropped.
- busy and done:
  - busy is registered.
  - done never coincides with pwm_wr for the same move.
- Reset mid-dwell: returns to IDLE immediately with the FIFO cleared; the PWM core keeps its last programmed duty.

Optional Feature:
- Macro: PWM_SEQ_READBACK_EN.
- When defined:
  - After WRITE, the FSM enters a VERIFY state: pwm_rd = 1 for one cycle with the same pwm_addr, then the compare happens the next cycle.
  - If pwm_q[DUTY_W-1:0] ≠ duty, a sticky extra output port err (1 bit) goes high, cleared by rst or abort.
  - The dwell then proceeds as normal.
  - Write-to-done spacing becomes dwell+3 cycles.
- When undefined: no VERIFY state, no err port, pwm_rd is tied 0, and pwm_q is unused.

Decomposition:
- Shared package pwm_seq_pkg holds:
  - the state enum (IDLE, LOAD, WRITE, DWELL, VERIFY);
  - the command struct {ch, duty, dwell};
  - the channel-stride constant 4 and the channel count 8.
- One sub-module, pwm_cmd_fifo: a synchronous FIFO with DEPTH and WIDTH parameters, asynchronous reset, and full/empty/level outputs. The FSM and counter stay in the top level.

Test Plan:
- Single move, idle start:
  - Stimulus: push ch=2, duty=16'h1234, dwell=5.
  - Response: pwm_wr on cycle 3 after the push with pwm_addr=8'h08 and pwm_data=32'h00001234; done exactly 6 cycles after pwm_wr; busy falls the cycle after done.
- Back-to-back:
  - Stimulus: push 3 moves (ch 0/1/7, dwell 0/2/1).
  - Response: writes to addresses 00/04/1C in order; done pulses 1, 3 and 2 cycles after their respective writes; the next move's pwm_wr comes 2 cycles after the previous done.
- FIFO full and wrap:
  - Stimulus: push 10 commands with the sequencer stalled on dwell=1000.
  - Response: cmd_ready=0 when level=8 and excess pushes are dropped; after draining, 20 further pushes/pops wrap cleanly and the write order equals the push order.
- Abort mid-dwell:
  - Stimulus: 4 queued moves; assert abort 10 cycles into the first dwell.
  - Response: next cycle IDLE, level=0, busy=0; no further pwm_wr and no done.
- Asynchronous reset:
  - Stimulus: assert rst between clock edges during DWELL.
  - Response: outputs clear immediately without waiting for a clock edge; cmd_ready=1; a push after reset is accepted normally.
- Readback (PWM_SEQ_READBACK_EN):
  - Stimulus: PWM model returns duty^1.
  - Response: pwm_rd pulses one cycle after pwm_wr; err rises and stays high until abort.
